i2c_target_regfile: RTL
=======================

Name: i2c_target_regfile

Overview:
- Parametrised successor to the bench-level I2C slave: a synthesizable, clk-synchronous I2C target with an internal register file of NUM_REGS bytes.
- Oversamples SCL/SDA and detects START, repeated START and STOP.
- Supports a register pointer with auto-increment, multi-byte writes/reads and NACK on address mismatch.
- Sits between the board-level open-drain pads (sda_oe drives low) and local logic, which can load and read registers.

Parameters:
- ADDRESS, 7'h2A, 7-bit target address.
- NUM_REGS, 16, register file depth (2..256); PTR_W = $clog2(NUM_REGS).
- SYNC_STAGES, 2, synchroniser depth for scl_i/sda_i (>=2).

Ports:
- clk  input  1  system clock, >= 8x SCL rate.
- rst  input  1  asynchronous, active-high reset.
- scl_i  input  1  SCL pad input.
- sda_i  input  1  SDA pad input.
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- lcl_we  input  1  local register write strobe.
- lcl_addr  input  PTR_W  local write/read address.
- lcl_wdata  input  8  local write data.
- lcl_rdata  output  8  reg[lcl_addr], registered, 1-cycle latency.
- wr_valid  output  1  1-cycle pulse: I2C wrote a register.
- wr_addr  output  PTR_W  address of that write.
- wr_data  output  8  data of that write.
- busy  output  1  high from address-matched ACK until STOP.

Behaviour:
- Reset (async, active-high): all regs 0, pointer 0, state IDLE; sda_oe, wr_valid, busy = 0; lcl_rdata = 0; synchronisers preset to 1 (idle bus).
- Bus events, on synchronised signals:
  - START = SDA 1->0 while SCL=1.
  - STOP = SDA 0->1 while SCL=1.
  - Data is sampled on the SCL rising edge.
  - sda_oe updates in the cycle after an SCL falling edge is detected. Worst case: SYNC_STAGES+2 clk after the pad edge.
- Bit order: MSB first.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
  - IDLE: START -> ADDR.
  - ADDR: shift 8 bits. Match (addr[7:1]==ADDRESS) -> ADDR_ACK. Mismatch -> IDLE with no ACK.
  - ADDR_ACK: drive ACK low for one SCL period. Then R/W=0 -> PTR; R/W=1 -> RD_BYTE, first byte = reg[pointer].
  - PTR: 8 bits received -> pointer = byte[PTR_W-1:0] (upper bits ignored) -> WR_ACK, then WR_BYTE.
  - WR_BYTE: 8 bits -> reg[pointer] <= byte; wr_valid pulse carries the pre-increment pointer; pointer++ -> WR_ACK -> WR_BYTE.
  - RD_BYTE: drive reg[pointer] bits (sda_oe = ~bit). After bit 0: release SDA, pointer++ -> RD_ACK.
  - RD_ACK: master ACK (SDA=0) -> RD_BYTE, loading the next byte on the SCL fall. Master NACK -> IDLE, SDA released.
- Pointer wrap: NUM_REGS-1 increments to 0.
- Repeated START in any state -> ADDR. Pointer retained, enabling write-pointer-then-read.
- STOP in any state -> IDLE; sda_oe = 0 in the next clk; busy = 0.
- The byte being read is latched at the start of RD_BYTE. A local write during the byte affects only the next read.
- Same-cycle lcl_we and I2C write to the same register: I2C wins; the local write is dropped.
- Async reset mid-transfer releases SDA immediately. The bus is then ignored until the next START.

Optional Feature:
- Macro: I2C_TARGET_REGFILE_GENERAL_CALL_EN.
- Enabled: address byte 0x00 (general call, write) is ACKed. Subsequent data bytes are ACKed and written to reg[NUM_REGS-1] with wr_valid pulsed. The pointer is unaffected. busy stays 0.
- Disabled: 0x00 is treated as a mismatch and NACKed; no register changes.

Decomposition:
- Package i2c_target_pkg: FSM state enum; ACK=1'b0 and NACK=1'b1 constants; a default-address localparam.
- Sub-module i2c_bus_monitor: synchronisers, edge detects, and START/STOP/scl_rise/scl_fall pulses.
- FSM and register file stay in the top module.

Test Plan:
- Write 0x54 (addr 0x2A, W), ptr 0x03, data 0xA5, 0x3C, STOP -> ACK on all 4 bytes; wr_valid pulses (3,0xA5) and (4,0x3C); lcl_rdata at addr 4 = 0x3C.
- Write ptr 0x04, repeated START, 0x55 (R), master ACK, then NACK -> bytes 0x3C, 0x00 returned; SDA released after the NACK; busy=0 after STOP.
- Address 0x56 (0x2B, W) -> no ACK (sda_oe stays 0 throughout); FSM IDLE; no wr_valid.
- Write ptr 0x0F, data 0x11, 0x22 with NUM_REGS=16 -> reg15=0x11, reg0=0x22 (wrap).
- lcl_we to addr 5 (0x77) in the same cycle as an I2C write to addr 5 (0x99) -> reg5=0x99. Assert rst mid-read -> sda_oe=0 the same cycle.
- With GENERAL_CALL_EN: 0x00 then data 0xE1 -> ACKed; reg[15]=0xE1. Without it -> NACK; reg[15] unchanged.

Source files
------------

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register file.
package i2c_target_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [6:0] DEFAULT_ADDRESS = 7'h2A;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises SCL/SDA and flags START, STOP and SCL edges as 1-clk pulses.
// Latency SYNC_STAGES clk from pad edge to pulse; no backpressure.
module i2c_bus_monitor
  import i2c_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic start,
  output logic stop,
  output logic scl_rise,
  output logic scl_fall
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl;

  // Preset to 1 so a reset looks like an idle bus and raises no false events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_sync[SYNC_STAGES-1];
      sda_q    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl      = scl_sync[SYNC_STAGES-1];
  assign sda      = sda_sync[SYNC_STAGES-1];
  assign start    = scl & scl_q & sda_q & ~sda;
  assign stop     = scl & scl_q & ~sda_q & sda;
  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with NUM_REGS-byte register file, auto-incrementing pointer; optional I2C_TARGET_REGFILE_GENERAL_CALL_EN.
// sda_oe updates 1 clk after a detected SCL fall; the bus itself is the only flow control (no clock stretching).
module i2c_target_regfile
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] ADDRESS     = DEFAULT_ADDRESS,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        PTR_W       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic             lcl_we,
  input  logic [PTR_W-1:0] lcl_addr,
  input  logic [7:0]       lcl_wdata,
  output logic [7:0]       lcl_rdata,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  localparam logic [PTR_W-1:0] LAST    = PTR_W'(NUM_REGS - 1);
  localparam logic [PTR_W:0]   NREGS_W = (PTR_W+1)'(NUM_REGS);

  logic sda, start, stop, scl_rise, scl_fall;

  i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda      (sda),
    .start    (start),
    .stop     (stop),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall)
  );

  state_t           state, state_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic             full, full_nxt;
  logic [7:0]       sh, sh_nxt, rd_sh, rd_sh_nxt, rx_byte, rd_cur;
  logic [PTR_W-1:0] ptr, ptr_nxt, i2c_waddr;
  logic             sda_oe_nxt, busy_nxt, rw, rw_nxt, gc, gc_nxt, i2c_we;
  logic [7:0]       regs [NUM_REGS];

  function automatic logic in_range(input logic [PTR_W-1:0] a);
    return {1'b0, a} < NREGS_W;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign rx_byte = {sh[6:0], sda};
  assign rd_cur  = in_range(ptr) ? regs[ptr] : 8'h00;

  // full marks a completed byte/bit-phase waiting for the next SCL fall.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    full_nxt    = full;
    sh_nxt      = sh;
    rd_sh_nxt   = rd_sh;
    ptr_nxt     = ptr;
    sda_oe_nxt  = sda_oe;
    busy_nxt    = busy;
    rw_nxt      = rw;
    gc_nxt      = gc;
    i2c_we      = 1'b0;
    i2c_waddr   = ptr;
    if (stop) begin
      state_nxt  = IDLE;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
      full_nxt   = 1'b0;
      gc_nxt     = 1'b0;
    end else if (start) begin
      state_nxt   = ADDR;
      sda_oe_nxt  = 1'b0;
      bit_cnt_nxt = '0;
      full_nxt    = 1'b0;
      gc_nxt      = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WR_BYTE: begin
          if (scl_rise && !full) begin
            sh_nxt      = rx_byte;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              full_nxt = 1'b1;
              case (state)
                ADDR: begin
                  rw_nxt = rx_byte[0];
                  if (rx_byte[7:1] == ADDRESS) begin
                    gc_nxt = 1'b0;
`ifdef I2C_TARGET_REGFILE_GENERAL_CALL_EN
                  end else if (rx_byte == 8'h00) begin
                    gc_nxt = 1'b1;
`endif
                  end else begin
                    state_nxt = IDLE;
                    full_nxt  = 1'b0;
                  end
                end
                PTR: ptr_nxt = rx_byte[PTR_W-1:0];
                default: begin
                  i2c_we    = 1'b1;
                  i2c_waddr = gc ? LAST : ptr;
                  if (!gc) ptr_nxt = ptr_inc(ptr);
                end
              endcase
            end
          end else if (scl_fall && full) begin
            full_nxt   = 1'b0;
            sda_oe_nxt = ~ACK;
            if (state == ADDR) begin
              state_nxt = ADDR_ACK;
              if (!gc) busy_nxt = 1'b1;
            end else begin
              state_nxt = WR_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_nxt = '0;
            if (rw) begin
              state_nxt  = RD_BYTE;
              rd_sh_nxt  = rd_cur;
              sda_oe_nxt = ~rd_cur[7];
            end else begin
              state_nxt  = gc ? WR_BYTE : PTR;
              sda_oe_nxt = 1'b0;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_nxt   = WR_BYTE;
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = '0;
          end
        end
        RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) full_nxt = 1'b1;
          end else if (scl_fall) begin
            if (full) begin
              full_nxt   = 1'b0;
              sda_oe_nxt = 1'b0;
              ptr_nxt    = ptr_inc(ptr);
              state_nxt  = RD_ACK;
            end else begin
              rd_sh_nxt  = {rd_sh[6:0], 1'b0};
              sda_oe_nxt = ~rd_sh[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda == ACK) full_nxt = 1'b1;
            else            state_nxt = IDLE;
          end else if (scl_fall && full) begin
            full_nxt    = 1'b0;
            bit_cnt_nxt = '0;
            rd_sh_nxt   = rd_cur;
            sda_oe_nxt  = ~rd_cur[7];
            state_nxt   = RD_BYTE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      full     <= 1'b0;
      sh       <= '0;
      rd_sh    <= '0;
      ptr      <= '0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      rw       <= 1'b0;
      gc       <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      full     <= full_nxt;
      sh       <= sh_nxt;
      rd_sh    <= rd_sh_nxt;
      ptr      <= ptr_nxt;
      sda_oe   <= sda_oe_nxt;
      busy     <= busy_nxt;
      rw       <= rw_nxt;
      gc       <= gc_nxt;
      wr_valid <= i2c_we;
      wr_addr  <= i2c_waddr;
      wr_data  <= rx_byte;
    end
  end

  // A colliding local write to the register I2C is writing is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
      lcl_rdata <= 8'h00;
    end else begin
      if (lcl_we && in_range(lcl_addr) && !(i2c_we && i2c_waddr == lcl_addr))
        regs[lcl_addr] <= lcl_wdata;
      if (i2c_we && in_range(i2c_waddr))
        regs[i2c_waddr] <= rx_byte;
      lcl_rdata <= in_range(lcl_addr) ? regs[lcl_addr] : 8'h00;
    end
  end

endmodule
